// File: rtl/testimage_check_if.sv
// Pixel stream bus between a video source (master) and the test-image checker (slave).
//
// Handshake: a beat transfers on a rising clock edge where s_axis_tvalid and
// s_axis_tready are both high. The master holds data, strobe and last stable
// while tvalid is high and tready is low. The slave drives tready from a
// register, never combinationally from tvalid.
interface testimage_check_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tstrb;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;

  modport master (
    output s_axis_tdata,
    output s_axis_tstrb,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tstrb,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/testimage_check.sv
// testimage_check: stream sink that checks the VGA test image pixel by pixel.
// Pixel k (1-based) must carry {k[7:0], k[7:0], k[7:0]} in tdata[23:0].
// Started/stopped by the CHECKON level (synchronised through three flops).
// Optional feature macro: TESTIMAGE_CHECK_TLAST_EN -- also checks that tlast
// is high exactly on the last pixel of each line.
module testimage_check #(
  parameter int C_S_AXIS_DATA_WIDTH = 24,
  parameter int H_ACTIVE            = 640,
  parameter int V_ACTIVE            = 480
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  testimage_check_if.slave    s_axis,
  input  logic                CHECKON,
  output logic                CHECKEND,
  output logic [31:0]         CHECK_PIXELCNT,
  output logic [31:0]         CHECK_ERRCNT,
  output logic [31:0]         CHECK_FIRSTERR,
  output logic                CHECK_OK,
  output logic [1:0]          dbg_state
);

  localparam logic [31:0] FRAME  = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic [31:0] H_LAST = 32'(H_ACTIVE - 1);

  if (C_S_AXIS_DATA_WIDTH < 24) begin : g_bad_width
    $error("testimage_check needs at least 24 data bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  on_ff;
  logic        start;
  logic        stop;
  logic        beat;
  logic [31:0] pix_next;
  logic [31:0] err_next;
  logic        mismatch;
  logic        frame_end;
  logic        unused_bits;

  assign start     = (on_ff[2:1] == 2'b01);
  assign stop      = ~on_ff[1];
  assign dbg_state = state;

  // tstrb and any data bits above the pixel are intentionally not checked
  assign unused_bits = ^{s_axis.s_axis_tstrb, s_axis.s_axis_tdata, s_axis.s_axis_tlast};

`ifdef TESTIMAGE_CHECK_TLAST_EN
  logic [31:0] col_cnt;  // position of the next pixel within its line
`endif

  // Evaluate the beat on the bus: next pixel index, expected value and error
  always_comb begin
    beat      = s_axis.s_axis_tvalid & s_axis.s_axis_tready;
    pix_next  = CHECK_PIXELCNT + 32'd1;
    mismatch  = (s_axis.s_axis_tdata[23:0] != {3{pix_next[7:0]}});
`ifdef TESTIMAGE_CHECK_TLAST_EN
    mismatch  = mismatch | (s_axis.s_axis_tlast != (col_cnt == H_LAST));
`endif
    err_next  = (CHECK_ERRCNT == 32'hFFFF_FFFF) ? CHECK_ERRCNT : CHECK_ERRCNT + 32'd1;
    frame_end = (pix_next == FRAME);
  end

  // Enable synchroniser, control FSM, counters and registered status outputs.
  // tready/CHECKEND are also gated by on_ff[0] so a dropped enable shows up one
  // edge before the FSM itself returns to IDLE.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state                <= ST_IDLE;
      on_ff                <= 3'b000;
      s_axis.s_axis_tready <= 1'b0;
      CHECKEND             <= 1'b0;
      CHECK_OK             <= 1'b0;
      CHECK_PIXELCNT       <= 32'd0;
      CHECK_ERRCNT         <= 32'd0;
      CHECK_FIRSTERR       <= 32'd0;
`ifdef TESTIMAGE_CHECK_TLAST_EN
      col_cnt              <= 32'd0;
`endif
    end else begin
      on_ff <= {on_ff[1:0], CHECKON};
      case (state)
        ST_IDLE: begin
          CHECKEND <= 1'b0;
          CHECK_OK <= 1'b0;
          if (start) begin
            CHECK_PIXELCNT       <= 32'd0;
            CHECK_ERRCNT         <= 32'd0;
            CHECK_FIRSTERR       <= 32'd0;
`ifdef TESTIMAGE_CHECK_TLAST_EN
            col_cnt              <= 32'd0;
`endif
            state                <= ST_RUN;
            s_axis.s_axis_tready <= on_ff[0];
          end
        end
        ST_RUN: begin
          if (beat) begin
            CHECK_PIXELCNT <= pix_next;
            if (mismatch) begin
              CHECK_ERRCNT <= err_next;
              if (CHECK_ERRCNT == 32'd0) CHECK_FIRSTERR <= pix_next;
            end
`ifdef TESTIMAGE_CHECK_TLAST_EN
            col_cnt <= (col_cnt == H_LAST) ? 32'd0 : col_cnt + 32'd1;
`endif
          end
          if (stop) begin
            state                <= ST_IDLE;
            s_axis.s_axis_tready <= 1'b0;
            CHECKEND             <= 1'b0;
            CHECK_OK             <= 1'b0;
          end else if (beat && frame_end) begin
            state                <= ST_DONE;
            s_axis.s_axis_tready <= 1'b0;
            CHECKEND             <= on_ff[0];
            CHECK_OK             <= on_ff[0] & (CHECK_ERRCNT == 32'd0) & ~mismatch;
          end else begin
            s_axis.s_axis_tready <= on_ff[0];
          end
        end
        ST_DONE: begin
          s_axis.s_axis_tready <= 1'b0;
          if (stop) begin
            state    <= ST_IDLE;
            CHECKEND <= 1'b0;
            CHECK_OK <= 1'b0;
          end else begin
            CHECKEND <= CHECKEND & on_ff[0];
            CHECK_OK <= CHECK_OK & on_ff[0];
          end
        end
        default: begin
          state                <= ST_IDLE;
          s_axis.s_axis_tready <= 1'b0;
          CHECKEND             <= 1'b0;
          CHECK_OK             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_testimage_check.sv
// Directed bench for testimage_check using a reduced 64x40 frame.
module tb_testimage_check;

  localparam int H     = 64;
  localparam int V     = 40;
  localparam int FRAME = H * V;   // 2560
  localparam int NONE  = -1;

  logic        clk;
  logic        aresetn;
  logic        checkon;
  logic        checkend;
  logic [31:0] pixelcnt;
  logic [31:0] errcnt;
  logic [31:0] firsterr;
  logic        check_ok;
  logic [1:0]  dbg_state;

  logic [23:0] exp_q[$];   // expected pixel values, index p-1 for pixel p
  int          n_checks;
  int          n_fail;

  testimage_check_if #(.DATA_WIDTH(24)) bus ();

  testimage_check #(
    .C_S_AXIS_DATA_WIDTH(24),
    .H_ACTIVE(H),
    .V_ACTIVE(V)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .s_axis        (bus.slave),
    .CHECKON       (checkon),
    .CHECKEND      (checkend),
    .CHECK_PIXELCNT(pixelcnt),
    .CHECK_ERRCNT  (errcnt),
    .CHECK_FIRSTERR(firsterr),
    .CHECK_OK      (check_ok),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // drive pixels first..last; bad_a/bad_b are sent as zero, no_tlast has tlast low
  task automatic drive_beats(input int first, input int last, input int bad_a,
                             input int bad_b, input int no_tlast, input bit rnd);
    int p;
    int cyc;
    logic v;
    logic acc;
    p   = first;
    cyc = 0;
    while (p <= last && cyc < 20000) begin
      v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.s_axis_tvalid = v;
      bus.s_axis_tdata  = (p == bad_a || p == bad_b) ? 24'h000000 : exp_q[p-1];
      bus.s_axis_tlast  = ((p % H) == 0) && (p != no_tlast);
      acc = v & bus.s_axis_tready;
      tick();
      if (acc) p++;
      cyc++;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check("drive_done", 32'(p > last), 32'd1);
  endtask

  task automatic check_frame_end(input string tag, input logic [31:0] e_err,
                                 input logic [31:0] e_first, input logic e_ok);
    check({tag, "_end"},   32'(checkend), 32'd1);
    check({tag, "_cnt"},   pixelcnt, 32'(FRAME));
    check({tag, "_err"},   errcnt, e_err);
    check({tag, "_first"}, firsterr, e_first);
    check({tag, "_ok"},    32'(check_ok), 32'(e_ok));
    check({tag, "_rdy"},   32'(bus.s_axis_tready), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd2);
  endtask

  // drop and re-raise the enable; counts must clear as tready comes back
  task automatic restart(input string tag);
    checkon = 1'b0;
    repeat (4) tick();
    check({tag, "_off_rdy"}, 32'(bus.s_axis_tready), 32'd0);
    check({tag, "_off_end"}, 32'(checkend), 32'd0);
    checkon = 1'b1;
    repeat (3) tick();
    check({tag, "_on_rdy"}, 32'(bus.s_axis_tready), 32'd1);
    check({tag, "_on_cnt"}, pixelcnt, 32'd0);
    check({tag, "_on_err"}, errcnt, 32'd0);
    check({tag, "_on_first"}, firsterr, 32'd0);
  endtask

  // directed sequence
  initial begin
    logic [7:0] b;
    n_checks          = 0;
    n_fail            = 0;
    aresetn           = 1'b0;
    checkon           = 1'b1;
    bus.s_axis_tdata  = 24'h0;
    bus.s_axis_tstrb  = 3'b111;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      b = 8'(i % 256);
      exp_q.push_back({b, b, b});
    end

    // reset held 4 cycles with the enable high
    repeat (4) tick();
    check("rst_rdy",   32'(bus.s_axis_tready), 32'd0);
    check("rst_end",   32'(checkend), 32'd0);
    check("rst_ok",    32'(check_ok), 32'd0);
    check("rst_cnt",   pixelcnt, 32'd0);
    check("rst_err",   errcnt, 32'd0);
    check("rst_first", firsterr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    aresetn = 1'b1;
    tick();
    tick();
    check("start_rdy_e2", 32'(bus.s_axis_tready), 32'd0);
    tick();
    check("start_rdy_e3", 32'(bus.s_axis_tready), 32'd1);
    check("start_state",  32'(dbg_state), 32'd1);

    // clean frame, tvalid always high; includes byte wrap at 256/257
    drive_beats(1, 300, NONE, NONE, NONE, 1'b0);
    check("clean_mid_cnt", pixelcnt, 32'd300);
    check("clean_mid_err", errcnt, 32'd0);
    drive_beats(301, FRAME, NONE, NONE, NONE, 1'b0);
    check_frame_end("clean", 32'd0, 32'd0, 1'b1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 24'h010101;
    repeat (5) tick();
    bus.s_axis_tvalid = 1'b0;
    check("clean_hold_cnt", pixelcnt, 32'(FRAME));

    // pixels 1000 (expects e8e8e8) and 2000 sent as zero
    restart("err");
    drive_beats(1, 1000, 1000, 2000, NONE, 1'b0);
    check("err_mid_err",   errcnt, 32'd1);
    check("err_mid_first", firsterr, 32'd1000);
    drive_beats(1001, FRAME, 1000, 2000, NONE, 1'b0);
    check_frame_end("err", 32'd2, 32'd1000, 1'b0);

    // tvalid at random 50% duty, then held high after the frame
    restart("rnd");
    drive_beats(1, FRAME, NONE, NONE, NONE, 1'b1);
    check_frame_end("rnd", 32'd0, 32'd0, 1'b1);
    bus.s_axis_tvalid = 1'b1;
    repeat (5) tick();
    bus.s_axis_tvalid = 1'b0;
    check("rnd_hold_cnt", pixelcnt, 32'(FRAME));

    // abort at pixel 500, then a clean restart
    restart("abort");
    drive_beats(1, 500, NONE, NONE, NONE, 1'b0);
    checkon = 1'b0;
    tick();
    check("abort_rdy_e0", 32'(bus.s_axis_tready), 32'd1);
    tick();
    check("abort_rdy_e1", 32'(bus.s_axis_tready), 32'd0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = exp_q[500];
    repeat (4) tick();
    bus.s_axis_tvalid = 1'b0;
    check("abort_end",   32'(checkend), 32'd0);
    check("abort_cnt",   pixelcnt, 32'd500);
    check("abort_state", 32'(dbg_state), 32'd0);
    checkon = 1'b1;
    repeat (3) tick();
    check("abort_re_rdy", 32'(bus.s_axis_tready), 32'd1);
    check("abort_re_cnt", pixelcnt, 32'd0);
    drive_beats(1, FRAME, NONE, NONE, NONE, 1'b0);
    check_frame_end("abort_re", 32'd0, 32'd0, 1'b1);

    // tlast missing on pixel 1920 (end of line 30)
    restart("tlast");
    drive_beats(1, FRAME, NONE, NONE, 1920, 1'b0);
`ifdef TESTIMAGE_CHECK_TLAST_EN
    check_frame_end("tlast", 32'd1, 32'd1920, 1'b0);
`else
    check_frame_end("tlast", 32'd0, 32'd0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
